// File: rtl/mlp_eval_pkg.sv
// Shared types and defaults for the MLP test sequencer.
package mlp_eval_pkg;

  localparam int NUM_CLASSES_DEF = 10;
  localparam int SCORE_W_DEF     = 8;

  localparam logic [3:0] CLASS_NONE = 4'hF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    EVAL   = 3'd3,
    NEXT   = 3'd4,
    DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/mlp_test_sequencer_if.sv
// Handshake and result bus between the sequencer and the MLP core.
interface mlp_test_sequencer_if
  import mlp_eval_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int SCORE_W     = SCORE_W_DEF
);

  logic                           mlp_start;
  logic                           mlp_done;
  logic [NUM_CLASSES-1:0]         mlp_maxi;
  logic [NUM_CLASSES*SCORE_W-1:0] mlp_answer;

  modport master (
    output mlp_start,
    input  mlp_done,
    input  mlp_maxi,
    input  mlp_answer
  );

  modport slave (
    input  mlp_start,
    output mlp_done,
    output mlp_maxi,
    output mlp_answer
  );

endinterface

// File: rtl/mlp_onehot_decode.sv
// Decodes the MLP argmax vector into a class index; the lowest set bit wins
// when the vector is not strictly one-hot.
module mlp_onehot_decode
  import mlp_eval_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF
) (
  input  logic [NUM_CLASSES-1:0] maxi,
  output logic [3:0]             class_idx,
  output logic                   exactly_one,
  output logic                   none
);

  localparam logic [NUM_CLASSES-1:0] LSB_ONE = {{(NUM_CLASSES-1){1'b0}}, 1'b1};

  // Priority scan from the top so the lowest set index is the last writer
  always_comb begin
    class_idx = CLASS_NONE;
    for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
      if (maxi[i]) begin
        class_idx = 4'(i);
      end else begin
        class_idx = class_idx;
      end
    end
    none        = (maxi == '0);
    exactly_one = !none && ((maxi & (maxi - LSB_ONE)) == '0);
  end

endmodule

// File: rtl/mlp_test_sequencer.sv
// Steps the MLP through the test set, scores each prediction against the
// label ROM and keeps accuracy counters plus sticky error flags.
module mlp_test_sequencer
  import mlp_eval_pkg::*;
#(
  parameter int N_SAMPLES   = 750,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int IDX_W       = 10,
  parameter int TIMEOUT     = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [3:0]           label,
  mlp_test_sequencer_if.master mlp,
  output logic [IDX_W-1:0]     sample_idx,
  output logic                 pred_valid,
  output logic [3:0]           pred_class,
  output logic [SCORE_W-1:0]   pred_score,
  output logic [IDX_W-1:0]     correct_cnt,
  output logic [IDX_W-1:0]     total_cnt,
  output logic                 busy,
  output logic                 finished,
  output logic                 onehot_err,
  output logic                 timeout_err
);

  localparam int              WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [4:0]      NC5      = 5'(NUM_CLASSES);

  state_e             state_q, state_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [IDX_W-1:0]   idx_q, idx_d, correct_q, correct_d, total_q, total_d;
  logic [3:0]         pred_class_q, pred_class_d;
  logic [SCORE_W-1:0] pred_score_q, pred_score_d, score_s;
  logic               pred_valid_q, pred_valid_d, start_q, start_d;
  logic               busy_q, busy_d, finished_q, finished_d;
  logic               onehot_err_q, onehot_err_d, timeout_err_q, timeout_err_d;
  logic               done_q;
  logic [3:0]         dec_class_s;
  logic               exactly_one_s, none_s, done_edge_s, match_s;

  mlp_onehot_decode #(.NUM_CLASSES(NUM_CLASSES)) u_decode (
    .maxi        (mlp.mlp_maxi),
    .class_idx   (dec_class_s),
    .exactly_one (exactly_one_s),
    .none        (none_s)
  );

  // Score of the decoded class; stays zero when no class was decoded
  always_comb begin
    score_s = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      score_s = score_s | (mlp.mlp_answer[i*SCORE_W +: SCORE_W] & {SCORE_W{dec_class_s == 4'(i)}});
    end
  end

  assign done_edge_s = mlp.mlp_done & ~done_q;
  assign match_s     = exactly_one_s && ({1'b0, label} < NC5) && (dec_class_s == label);

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    idx_d         = idx_q;
    correct_d     = correct_q;
    total_d       = total_q;
    pred_class_d  = pred_class_q;
    pred_score_d  = pred_score_q;
    pred_valid_d  = 1'b0;
    start_d       = 1'b0;
    onehot_err_d  = onehot_err_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE, DONE: begin
        if (run) begin
          state_d       = LAUNCH;
          start_d       = 1'b1;
          idx_d         = '0;
          correct_d     = '0;
          total_d       = '0;
          onehot_err_d  = 1'b0;
          timeout_err_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      LAUNCH: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A fresh done edge takes priority over watchdog expiry
        if (done_edge_s) begin
          state_d      = EVAL;
          pred_valid_d = 1'b1;
          pred_class_d = dec_class_s;
          pred_score_d = score_s;
          total_d      = total_q + IDX_ONE;
          correct_d    = match_s ? (correct_q + IDX_ONE) : correct_q;
          onehot_err_d = onehot_err_q | ~exactly_one_s;
        end else if (wd_q == WD_LAST) begin
          state_d       = DONE;
          timeout_err_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      EVAL: begin
        state_d = NEXT;
      end
      NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          state_d = LAUNCH;
          start_d = 1'b1;
          idx_d   = idx_q + IDX_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d     = (state_d == LAUNCH) || (state_d == WAIT) || (state_d == EVAL) || (state_d == NEXT);
    finished_d = (state_d == DONE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      idx_q         <= '0;
      correct_q     <= '0;
      total_q       <= '0;
      pred_class_q  <= 4'h0;
      pred_score_q  <= '0;
      pred_valid_q  <= 1'b0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      finished_q    <= 1'b0;
      onehot_err_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      idx_q         <= idx_d;
      correct_q     <= correct_d;
      total_q       <= total_d;
      pred_class_q  <= pred_class_d;
      pred_score_q  <= pred_score_d;
      pred_valid_q  <= pred_valid_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      finished_q    <= finished_d;
      onehot_err_q  <= onehot_err_d;
      timeout_err_q <= timeout_err_d;
      done_q        <= mlp.mlp_done;
    end
  end

  assign mlp.mlp_start = start_q;
  assign sample_idx    = idx_q;
  assign pred_valid    = pred_valid_q;
  assign pred_class    = pred_class_q;
  assign pred_score    = pred_score_q;
  assign correct_cnt   = correct_q;
  assign total_cnt     = total_q;
  assign busy          = busy_q;
  assign finished      = finished_q;
  assign onehot_err    = onehot_err_q;
  assign timeout_err   = timeout_err_q;

endmodule
